bin_bcd_ctrl: RTL and testbench

BIN_BCD_CTRL -- requirements
Module: bin_bcd_ctrl

---
 rtl/bin_bcd_ctrl.sv | 132 +++++++++++++
 tb/tb_bin_bcd_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_ctrl.sv
// 8-bit binary to 3-digit BCD converter (shift-add-3), 10-cycle start-to-idle, with 7-seg decode.
// Start is ignored while busy; the BCD result holds until the next conversion completes.
module bin_bcd_ctrl #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [0:6]  hex2,
  output logic [0:6]  hex1,
  output logic [0:6]  hex0
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  count;
  logic [3:0]  count_inc;
  logic [7:0]  sr;
  logic [11:0] scratch;
  logic [11:0] adj;
  logic [19:0] shifted;

  // Add-3 correction on each digit before the shift keeps every nibble within 0-9
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted   = {adj[10:0], sr, 1'b0};
  assign count_inc = count + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count_inc == 4'd8) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 4'd0;
      sr      <= 8'd0;
      scratch <= 12'd0;
      bcd     <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= bin;
            scratch <= 12'd0;
            count   <= 4'd0;
          end
        end
        SHIFT: begin
          {scratch, sr} <= shifted;
          count         <= count_inc;
          if (count_inc == 4'd8) begin
            bcd <= shifted[19:8];
          end
        end
        default: begin
        end
      endcase
    end
  end

  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Tens is only blanked when hundreds is also zero, so 105 still shows its middle 0
  assign hex2 = (BLANK_LZ && bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
  assign hex1 = (BLANK_LZ && bcd[11:4] == 8'd0) ? SEG_BLANK : seg7(bcd[7:4]);
  assign hex0 = seg7(bcd[3:0]);

endmodule

// File: tb/tb_bin_bcd_ctrl.sv
// Directed bench for bin_bcd_ctrl: table of conversions plus timing, overlap and reset sequences.
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_bin_bcd_ctrl;

  localparam logic [0:6] BL = 7'b1111111;
  localparam logic [0:6] S0 = 7'b0000001;
  localparam logic [0:6] S1 = 7'b1001111;
  localparam logic [0:6] S2 = 7'b0010010;
  localparam logic [0:6] S4 = 7'b1001100;
  localparam logic [0:6] S5 = 7'b0100100;
  localparam logic [0:6] S7 = 7'b0001111;
  localparam logic [0:6] S8 = 7'b0000000;
  localparam logic [0:6] S9 = 7'b0000100;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [0:6]  h2;
    logic [0:6]  h1;
    logic [0:6]  h0;
    logic [0:6]  h2n;
    logic [0:6]  h1n;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy, done, busy_n, done_n;
  logic [11:0] bcd, bcd_n;
  logic [0:6]  hex2, hex1, hex0, hex2_n, hex1_n, hex0_n;

  int checks;
  int failures;
  int dcount;
  vec_t vecs[10];

  bin_bcd_ctrl #(.BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd),
    .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  bin_bcd_ctrl #(.BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy_n), .done(done_n), .bcd(bcd_n),
    .hex2(hex2_n), .hex1(hex1_n), .hex0(hex0_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{8'd0,   12'h000, BL, BL, S0, S0, S0};
    vecs[1] = '{8'd9,   12'h009, BL, BL, S9, S0, S0};
    vecs[2] = '{8'd10,  12'h010, BL, S1, S0, S0, S1};
    vecs[3] = '{8'd57,  12'h057, BL, S5, S7, S0, S5};
    vecs[4] = '{8'd99,  12'h099, BL, S9, S9, S0, S9};
    vecs[5] = '{8'd100, 12'h100, S1, S0, S0, S1, S0};
    vecs[6] = '{8'd128, 12'h128, S1, S2, S8, S1, S2};
    vecs[7] = '{8'd200, 12'h200, S2, S0, S0, S2, S0};
    vecs[8] = '{8'd255, 12'h255, S2, S5, S5, S2, S5};
    vecs[9] = '{8'd194, 12'h194, S1, S9, S4, S1, S9};

    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst bcd", 32'(bcd), 32'h000);
    chk("rst hex2", 32'(hex2), 32'(BL));
    chk("rst hex1", 32'(hex1), 32'(BL));
    chk("rst hex0", 32'(hex0), 32'(S0));
    chk("rst nb hex2", 32'(hex2_n), 32'(S0));
    chk("rst nb hex1", 32'(hex1_n), 32'(S0));
    rst = 1'b0;
    tick();

    // Single-pulse conversions; operand is scrambled right after capture
    for (int i = 0; i < 10; i++) begin
      bin   = vecs[i].bin;
      start = 1'b1;
      tick();
      start = 1'b0;
      bin   = ~vecs[i].bin;
      for (int k = 1; k <= 10; k++) begin
        chk($sformatf("v%0d busy c%0d", i, k), 32'(busy), 32'(k <= 9));
        chk($sformatf("v%0d done c%0d", i, k), 32'(done), 32'(k == 9));
        if (k == 9) begin
          chk($sformatf("v%0d bcd", i), 32'(bcd), 32'(vecs[i].bcd));
          chk($sformatf("v%0d hex2", i), 32'(hex2), 32'(vecs[i].h2));
          chk($sformatf("v%0d hex1", i), 32'(hex1), 32'(vecs[i].h1));
          chk($sformatf("v%0d hex0", i), 32'(hex0), 32'(vecs[i].h0));
          chk($sformatf("v%0d nb hex2", i), 32'(hex2_n), 32'(vecs[i].h2n));
          chk($sformatf("v%0d nb hex1", i), 32'(hex1_n), 32'(vecs[i].h1n));
          chk($sformatf("v%0d nb hex0", i), 32'(hex0_n), 32'(vecs[i].h0));
        end
        tick();
      end
      chk($sformatf("v%0d bcd hold", i), 32'(bcd), 32'(vecs[i].bcd));
    end

    // Start held high: back-to-back conversions every 10 cycles, operand changed mid-run
    bin   = 8'd100;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) bin = 8'd7;
      if (k == 25) start = 1'b0;
      chk($sformatf("held done c%0d", k), 32'(done), 32'(k == 9 || k == 19 || k == 29));
      if (k == 9)  chk("held bcd1", 32'(bcd), 32'h100);
      if (k == 15) chk("held bcd hold", 32'(bcd), 32'h100);
      if (k == 19) chk("held bcd2", 32'(bcd), 32'h007);
      tick();
    end
    chk("held idle busy", 32'(busy), 32'd0);

    // Start re-pulsed while busy is dropped, not queued
    bin   = 8'd33;
    start = 1'b1;
    tick();
    start  = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 4 || k == 9);
      if (done) dcount++;
      if (k == 9)  chk("ovl bcd", 32'(bcd), 32'h033);
      if (k == 10) chk("ovl busy c10", 32'(busy), 32'd0);
      if (k == 12) chk("ovl busy c12", 32'(busy), 32'd0);
      tick();
    end
    start = 1'b0;
    chk("ovl done count", 32'(dcount), 32'd1);

    // Reset mid-conversion aborts with no done; a later start converts afresh
    bin   = 8'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("pre bcd", 32'(bcd), 32'h042);
    tick();
    bin   = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst bcd", 32'(bcd), 32'h000);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    tick();
    rst    = 1'b0;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("post-rst no activity", 32'(dcount), 32'd0);
    chk("post-rst bcd", 32'(bcd), 32'h000);
    bin   = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("restart done", 32'(done), 32'd1);
    chk("restart bcd", 32'(bcd), 32'h200);
    chk("restart hex2", 32'(hex2), 32'(S2));
    tick();
    chk("restart idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
